// File: rtl/wr_sel_arbiter.sv
// Register-file write-select arbiter: grants one of {held B, A, B} per cycle and
// drives a registered one-hot write enable, optionally discarding zero-register writes.
module wr_sel_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = 31
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   a_valid,
    input  logic [ADDR_W-1:0]      a_sel,
    output logic                   a_ready,
    input  logic                   b_valid,
    input  logic [ADDR_W-1:0]      b_sel,
    output logic                   b_ready,
    output logic [2**ADDR_W-1:0]   wr_en,
    output logic [ADDR_W-1:0]      wr_sel,
    output logic                   wr_src,
    output logic [15:0]            drop_cnt
);

    localparam int                NREGS    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(ZERO_IDX);

    logic                hold_full_reg, hold_full_next;
    logic [ADDR_W-1:0]   hold_sel_reg,  hold_sel_next;
    logic [NREGS-1:0]    wr_en_reg,     wr_en_next;
    logic [ADDR_W-1:0]   wr_sel_reg,    wr_sel_next;
    logic                wr_src_reg,    wr_src_next;
    logic [15:0]         drop_cnt_reg,  drop_cnt_next;

    logic                grant_valid;
    logic [ADDR_W-1:0]   grant_sel;
    logic                grant_src;
    logic                suppress;

    // Ready is a pure function of the slot so there is no valid->ready path.
    assign a_ready = !hold_full_reg;
    assign b_ready = !hold_full_reg;

    always_comb begin
        grant_valid    = 1'b0;
        grant_sel      = '0;
        grant_src      = 1'b0;
        hold_full_next = hold_full_reg;
        hold_sel_next  = hold_sel_reg;
        if (hold_full_reg) begin
            grant_valid    = 1'b1;
            grant_sel      = hold_sel_reg;
            grant_src      = 1'b1;
            hold_full_next = 1'b0;
        end else if (a_valid) begin
            grant_valid = 1'b1;
            grant_sel   = a_sel;
            grant_src   = 1'b0;
            if (b_valid) begin
                hold_full_next = 1'b1;
                hold_sel_next  = b_sel;
            end
        end else if (b_valid) begin
            grant_valid = 1'b1;
            grant_sel   = b_sel;
            grant_src   = 1'b1;
        end
        // Flush still lets handshakes complete; the accepted requests are simply discarded.
        if (flush) begin
            grant_valid    = 1'b0;
            hold_full_next = 1'b0;
        end
    end

    assign suppress    = (ZERO_EN != 0) && grant_valid && (grant_sel == ZERO_SEL);
    assign wr_sel_next = grant_valid ? grant_sel : '0;
    assign wr_src_next = grant_valid ? grant_src : 1'b0;

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (suppress && (drop_cnt_reg != 16'hFFFF))
            drop_cnt_next = drop_cnt_reg + 16'd1;
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_decode
            assign wr_en_next[gi] = grant_valid && !suppress && (grant_sel == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full_reg <= 1'b0;
            hold_sel_reg  <= '0;
            wr_en_reg     <= '0;
            wr_sel_reg    <= '0;
            wr_src_reg    <= 1'b0;
            drop_cnt_reg  <= 16'd0;
        end else begin
            hold_full_reg <= hold_full_next;
            hold_sel_reg  <= hold_sel_next;
            wr_en_reg     <= wr_en_next;
            wr_sel_reg    <= wr_sel_next;
            wr_src_reg    <= wr_src_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    assign wr_en    = wr_en_reg;
    assign wr_sel   = wr_sel_reg;
    assign wr_src   = wr_src_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule
